univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal shift register built from the enabled,
//   asynchronously initialised D flip-flop: WIDTH bits with hold, shift
//   right, shift left and parallel load modes, and a programmable reset
//   value. Tracks how many shifts have happened since the last load, so
//   serialisers and deserialisers know when a word has fully moved through.
// PARAMETERS
//   WIDTH      8      register width in bits (>= 2)
//   RESET_VAL  {WIDTH{1'b1}}  value q takes while rst_n is low (preset generalised)
//   CW         $clog2(WIDTH+1)  shift counter width (derived, do not override)
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   e       in   1      active-high clock enable; 0 = hold everything
//   mode    in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d       in   WIDTH  parallel load data
//   sin_r   in   1      serial in for shift right (enters q[WIDTH-1])
//   sin_l   in   1      serial in for shift left (enters q[0])
//   rot     in   1      rotate select (present only with USR_ROTATE_EN)
//   q       out  WIDTH  register contents
//   sout_r  out  1      = q[0] (bit leaving on shift right), combinational
//   sout_l  out  1      = q[WIDTH-1] (bit leaving on shift left), combinational
//   cnt     out  CW     shifts since last load/reset, saturating at WIDTH
//   done    out  1      registered, 1 when cnt == WIDTH
// BEHAVIOUR
//   - Reset: rst_n low, at any time and independent of clk -> q=RESET_VAL,
//     cnt=0, done=0, held until rst_n rises; first update on the next
//     rising clk edge after release. Mid-shift reset discards all progress.
//   - Priority at each rising edge: rst_n low > e=0 (hold q, cnt, done) > mode.
//   - 00 hold: q, cnt, done unchanged.
//   - 01 shift right: q <= {sin_r, q[WIDTH-1:1]}; cnt <= min(cnt+1, WIDTH).
//   - 10 shift left: q <= {q[WIDTH-2:0], sin_l}; cnt <= min(cnt+1, WIDTH).
//   - 11 load: q <= d; cnt <= 0; done <= 0. Load wins over any pending count.
//   - Latency: one cycle from edge to q/cnt/done; sout_* follow q combinationally.
//   - done <= (next cnt == WIDTH); stays 1 while saturated until load or reset.
//   - cnt saturates: further shifts at cnt==WIDTH keep cnt=WIDTH, done=1; no wrap.
//   - Direction changes mid-word do not reset cnt; each shift counts once.
//   - No X propagation from unused serial inputs: sin_l is ignored in 01,
//     sin_r is ignored in 10, both are ignored in 00 and 11.
// CONFIGURATION
//   USR_ROTATE_EN defined: port rot exists; with rot=1 shifts are circular
//     (right: q <= {q[0], q[WIDTH-1:1]}; left: q <= {q[WIDTH-2:0], q[WIDTH-1]}),
//     sin_r/sin_l are ignored; cnt/done count as normal. rot=0 behaves as undefined.
//   USR_ROTATE_EN undefined: no rot port; shifts always take sin_r/sin_l.
// TESTING (WIDTH=8, RESET_VAL=8'hA5)
//   1. rst_n=0 mid-cycle, clk running -> q=8'hA5, cnt=0, done=0 immediately, before next edge.
//   2. rst_n=1, e=1, mode=11, d=8'h3C -> q=8'h3C, cnt=0; then e=0 with mode=01 for 3 edges -> q stays 8'h3C.
//   3. Load 8'h81, mode=01, sin_r=0, 8 edges -> sout_r sequence 1,0,0,0,0,0,0,1; q=8'h00, cnt=8, done=1; 9th edge -> cnt stays 8.
//   4. Load 8'h01, mode=10, sin_l=1, 3 edges -> q=8'h0F, cnt=3, done=0; then mode=11 d=8'hFF -> cnt=0, q=8'hFF.
//   5. Shift 5 edges, assert rst_n=0 between edges -> q=8'hA5, cnt=0 at once; release -> resumes from A5.
//   6. USR_ROTATE_EN: load 8'h96, rot=1, mode=10, 8 edges -> q back to 8'h96, done=1; without macro, build has no rot port.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with a saturating shift counter. Define USR_ROTATE_EN to add the rot port.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
    parameter int               CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [1:0]    MODE_HOLD = 2'b00;
    localparam logic [1:0]    MODE_SHR  = 2'b01;
    localparam logic [1:0]    MODE_SHL  = 2'b10;
    localparam logic [1:0]    MODE_LOAD = 2'b11;
    localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);

    logic             in_r;
    logic             in_l;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_sat;

`ifdef USR_ROTATE_EN
    // In rotate mode the bit falling off one end re-enters at the other.
    assign in_r = rot ? q[0]       : sin_r;
    assign in_l = rot ? q[WIDTH-1] : sin_l;
`else
    assign in_r = sin_r;
    assign in_l = sin_l;
`endif

    assign cnt_sat = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);

    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        case (mode)
            MODE_HOLD: begin
                q_nxt   = q;
                cnt_nxt = cnt;
            end
            MODE_SHR: begin
                q_nxt   = {in_r, q[WIDTH-1:1]};
                cnt_nxt = cnt_sat;
            end
            MODE_SHL: begin
                q_nxt   = {q[WIDTH-2:0], in_l};
                cnt_nxt = cnt_sat;
            end
            MODE_LOAD: begin
                q_nxt   = d;
                cnt_nxt = '0;
            end
            default: begin
                q_nxt   = q;
                cnt_nxt = cnt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RESET_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else if (e) begin
            q    <= q_nxt;
            cnt  <= cnt_nxt;
            done <= (cnt_nxt == CNT_FULL);
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5): directed scenarios
// plus random traffic against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int W = 8;
    localparam int C = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         e;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;
    logic         rot_sel;
    logic [W-1:0] q;
    logic         sout_r;
    logic         sout_l;
    logic [C-1:0] cnt;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    int m_q;
    int m_cnt;
    int m_done;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .e      (e),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
`ifdef USR_ROTATE_EN
        .rot    (rot_sel),
`endif
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .cnt    (cnt),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".q"},      32'(q),      32'(m_q));
        check_val({tag, ".cnt"},    32'(cnt),    32'(m_cnt));
        check_val({tag, ".done"},   32'(done),   32'(m_done));
        check_val({tag, ".sout_r"}, 32'(sout_r), 32'(m_q % 2));
        check_val({tag, ".sout_l"}, 32'(sout_l), 32'(m_q / 128));
    endtask

    // Reference model: word as an integer, shifts as multiply/divide by two.
    task automatic model_step(input logic en, input logic [1:0] md, input logic [W-1:0] dv,
                              input logic sr, input logic sl, input logic rt);
        int in_bit;
        if (!en) return;
        case (md)
            2'b01: begin
                in_bit = rt ? (m_q % 2) : int'(sr);
                m_q    = (m_q / 2) + in_bit * 128;
                m_cnt  = (m_cnt < W) ? m_cnt + 1 : W;
            end
            2'b10: begin
                in_bit = rt ? (m_q / 128) : int'(sl);
                m_q    = ((m_q * 2) % 256) + in_bit;
                m_cnt  = (m_cnt < W) ? m_cnt + 1 : W;
            end
            2'b11: begin
                m_q   = int'(dv);
                m_cnt = 0;
            end
            default: ;
        endcase
        m_done = (m_cnt == W) ? 1 : 0;
    endtask

    // Drive inputs, take one rising edge, compare 1 time unit later.
    task automatic apply(input string tag, input logic en, input logic [1:0] md,
                         input logic [W-1:0] dv, input logic sr, input logic sl, input logic rt);
        e = en; mode = md; d = dv; sin_r = sr; sin_l = sl; rot_sel = rt;
        @(posedge clk);
        model_step(en, md, dv, sr, sl, rt);
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between edges; checks take effect without a clock.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        m_q = 8'hA5; m_cnt = 0; m_done = 0;
        #1 check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    logic [7:0] sr_seq;

    initial begin
        rst_n = 1'b0; e = 1'b0; mode = 2'b00; d = '0;
        sin_r = 1'b0; sin_l = 1'b0; rot_sel = 1'b0;
        m_q = 8'hA5; m_cnt = 0; m_done = 0;
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        #3 rst_n = 1'b1;

        // Load, then disabled shifts must not move anything.
        apply("load3c", 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
        check_val("load3c.const", 32'(q), 32'h3C);
        for (int i = 0; i < 3; i++)
            apply("hold_e0", 1'b0, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0);
        check_val("hold_e0.const", 32'(q), 32'h3C);

        // Async reset mid-cycle with the clock running.
        async_reset("mid_rst");

        // Shift 8'h81 right; the bit leaving each edge is 1,0,0,0,0,0,0,1.
        apply("load81", 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
        sr_seq = 8'h81;
        for (int i = 0; i < 8; i++) begin
            check_val("sout_r_seq", 32'(sout_r), 32'(sr_seq[i]));
            apply("shr81", 1'b1, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        check_val("shr81.q",    32'(q),    32'h00);
        check_val("shr81.cnt",  32'(cnt),  32'd8);
        check_val("shr81.done", 32'(done), 32'd1);
        apply("shr_sat", 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
        check_val("shr_sat.cnt", 32'(cnt), 32'd8);

        // Shift left with sin_l=1, then load cancels the count.
        apply("load01", 1'b1, 2'b11, 8'h01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            apply("shl01", 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
        check_val("shl01.q",    32'(q),    32'h0F);
        check_val("shl01.cnt",  32'(cnt),  32'd3);
        check_val("shl01.done", 32'(done), 32'd0);
        apply("loadff", 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
        check_val("loadff.cnt", 32'(cnt), 32'd0);

        // Reset in the middle of a word, then resume from the reset value.
        for (int i = 0; i < 5; i++)
            apply("shr5", 1'b1, 2'b01, 8'h00, 1'(i), 1'b0, 1'b0);
        async_reset("rst_mid_word");
        apply("resume", 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
        check_val("resume.q", 32'(q), 32'h52);

`ifdef USR_ROTATE_EN
        apply("load96", 1'b1, 2'b11, 8'h96, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            apply("rotl", 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("rotl.q",    32'(q),    32'h96);
        check_val("rotl.done", 32'(done), 32'd1);
`endif

        // Random traffic, with occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            logic         r_e;
            logic [1:0]   r_md;
            logic [W-1:0] r_d;
            logic         r_rot;
            r_e  = ($urandom_range(0, 7) != 0);
            r_md = 2'($urandom_range(0, 3));
            // Loads kept rare so the counter regularly reaches saturation.
            if (r_md == 2'b11 && $urandom_range(0, 3) != 0)
                r_md = 2'($urandom_range(1, 2));
            r_d  = 8'($urandom);
`ifdef USR_ROTATE_EN
            r_rot = 1'($urandom);
`else
            r_rot = 1'b0;
`endif
            apply("rand", r_e, r_md, r_d, 1'($urandom), 1'($urandom), r_rot);
            if ($urandom_range(0, 49) == 0)
                async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
